// File: rtl/scan_master_pkg.sv
// Shared constants and FSM encoding for the scan_master JTAG command engine.
package scan_master_pkg;

  localparam logic [1:0] CMD_IR  = 2'b00;
  localparam logic [1:0] CMD_DR  = 2'b01;
  localparam logic [1:0] CMD_RST = 2'b10;

  localparam int RST_TMS_CNT = 5;

  typedef enum logic [3:0] {
    RST_SEQ,
    IDLE,
    SEL_DR,
    SEL_IR,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE,
    DRAIN,
    RESP
  } state_e;

endpackage

// File: rtl/scan_shift_reg.sv
// TDI shift-out register, TDO_LAT-deep capture-valid pipeline and the TDO capture register.
module scan_shift_reg
  import scan_master_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int TDO_LAT = 1,
  parameter int IDX_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [MAX_LEN-1:0] data_i,
  input  logic               adv_i,
  input  logic               shift_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               tdo_i,
  output logic               tdi_o,
  output logic [MAX_LEN-1:0] cap_o,
  output logic               busy_o
);

  logic [MAX_LEN-1:0] sreg_q;
  logic [MAX_LEN-1:0] cap_q;
  logic               tdi_q;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg_q <= '0;
      cap_q  <= '0;
      tdi_q  <= 1'b0;
    end else begin
      tdi_q <= adv_i & sreg_q[0];
      if (load_i) begin
        sreg_q <= data_i;
        cap_q  <= '0;
      end else begin
        if (adv_i) sreg_q <= sreg_q >> 1;
        if (wr_en) cap_q[wr_idx] <= tdo_i;
      end
    end
  end

  generate
    if (TDO_LAT == 0) begin : g_direct
      assign wr_en  = shift_i;
      assign wr_idx = idx_i;
      assign busy_o = 1'b0;
    end else begin : g_pipe
      logic [TDO_LAT-1:0]            v_q;
      logic [TDO_LAT-1:0][IDX_W-1:0] idx_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          v_q   <= '0;
          idx_q <= '0;
        end else begin
          v_q[0]   <= shift_i;
          idx_q[0] <= idx_i;
          for (int i = 1; i < TDO_LAT; i++) begin
            v_q[i]   <= v_q[i-1];
            idx_q[i] <= idx_q[i-1];
          end
        end
      end

      assign wr_en  = v_q[TDO_LAT-1];
      assign wr_idx = idx_q[TDO_LAT-1];

      // busy means a capture is still due after the coming edge
      if (TDO_LAT > 1) begin : g_busy
        assign busy_o = |v_q[TDO_LAT-2:0];
      end else begin : g_nobusy
        assign busy_o = 1'b0;
      end
    end
  endgenerate

  assign tdi_o = tdi_q;
  assign cap_o = cap_q;

endmodule

// File: rtl/scan_master.sv
// Command-driven JTAG master: IR/DR scans and TAP reset with TDO capture, on TCK.
// Optional expected-TDO compare is enabled by SCAN_MASTER_TDO_CHECK_EN.
module scan_master
  import scan_master_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6,
  parameter int IR_LEN  = 2,
  parameter int TDO_LAT = 1
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
`ifdef SCAN_MASTER_TDO_CHECK_EN
  ,
  input  logic [MAX_LEN-1:0] cmd_exp,
  input  logic [MAX_LEN-1:0] cmd_mask,
  output logic               rsp_mismatch
`endif
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // state   | meaning (TMS driven in this cycle)
  // RST_SEQ | five TMS=1 edges then one TMS=0 edge into Run-Test/Idle
  // IDLE    | TMS=0, cmd_ready=1, waiting for a command
  // SEL_DR  | TMS=1, Idle -> Select-DR
  // SEL_IR  | TMS=1, Select-DR -> Select-IR (IR scans only)
  // CAPTURE | TMS=0 twice: into Capture, then into Shift (cnt 0/1)
  // SHIFT   | TMS=0, shift edge cnt (bits 0..N-2)
  // EXIT1   | TMS=1, last shift edge, Shift -> Exit1
  // UPDATE  | TMS=1, Exit1 -> Update
  // DRAIN   | TMS=0, Update -> Idle, waits out late captures
  // RESP    | response held until rsp_ready

  state_e             state_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;
  logic               ir_q;
  logic               rst_cmd_q;
  logic               tms_q;
  logic               cmd_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;

  logic               hs;
  logic               dr_legal;
  logic               shift_cur;
  logic               tdi_adv;
  logic               busy;
  logic [MAX_LEN-1:0] cap;

  always_comb begin
    hs        = cmd_valid & cmd_ready_q;
    dr_legal  = (cmd_len != '0) && (int'(cmd_len) <= MAX_LEN);
    shift_cur = (state_q == SHIFT) || (state_q == EXIT1);
    tdi_adv   = ((state_q == CAPTURE) && (cnt_q != '0)) || (state_q == SHIFT);
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q     <= RST_SEQ;
      cnt_q       <= '0;
      len_q       <= '0;
      ir_q        <= 1'b0;
      rst_cmd_q   <= 1'b0;
      tms_q       <= 1'b1;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        RST_SEQ: begin
          if (cnt_q == LEN_W'(RST_TMS_CNT)) begin
            cnt_q <= '0;
            tms_q <= 1'b0;
            if (rst_cmd_q) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            tms_q <= (cnt_q != LEN_W'(RST_TMS_CNT - 1));
          end
        end
        IDLE: begin
          tms_q <= 1'b0;
          if (hs) begin
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            rst_cmd_q   <= 1'b0;
            if (cmd_type == CMD_RST) begin
              state_q   <= RST_SEQ;
              tms_q     <= 1'b1;
              rst_cmd_q <= 1'b1;
            end else if (cmd_type == CMD_IR) begin
              state_q <= SEL_DR;
              tms_q   <= 1'b1;
              ir_q    <= 1'b1;
              len_q   <= LEN_W'(IR_LEN);
            end else if ((cmd_type == CMD_DR) && dr_legal) begin
              state_q <= SEL_DR;
              tms_q   <= 1'b1;
              ir_q    <= 1'b0;
              len_q   <= cmd_len;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        SEL_DR: begin
          state_q <= ir_q ? SEL_IR : CAPTURE;
          tms_q   <= ir_q;
          cnt_q   <= '0;
        end
        SEL_IR: begin
          state_q <= CAPTURE;
          tms_q   <= 1'b0;
        end
        CAPTURE: begin
          if (cnt_q == '0) begin
            cnt_q <= LEN_W'(1);
            tms_q <= 1'b0;
          end else begin
            cnt_q <= '0;
            if (len_q == LEN_W'(1)) begin
              state_q <= EXIT1;
              tms_q   <= 1'b1;
            end else begin
              state_q <= SHIFT;
              tms_q   <= 1'b0;
            end
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == len_q - LEN_W'(2)) begin
            state_q <= EXIT1;
            tms_q   <= 1'b1;
          end else begin
            tms_q <= 1'b0;
          end
        end
        EXIT1: begin
          state_q <= UPDATE;
          tms_q   <= 1'b1;
        end
        UPDATE: begin
          state_q <= DRAIN;
          tms_q   <= 1'b0;
          cnt_q   <= '0;
        end
        DRAIN: begin
          tms_q <= 1'b0;
          if (!busy) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          tms_q <= 1'b0;
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= RST_SEQ;
          cnt_q   <= '0;
          tms_q   <= 1'b1;
        end
      endcase
    end
  end

  scan_shift_reg #(
    .MAX_LEN (MAX_LEN),
    .TDO_LAT (TDO_LAT),
    .IDX_W   (IDX_W)
  ) u_shift (
    .clk_i   (TCK),
    .rst_i   (TRST),
    .load_i  (hs),
    .data_i  (cmd_data),
    .adv_i   (tdi_adv),
    .shift_i (shift_cur),
    .idx_i   (cnt_q[IDX_W-1:0]),
    .tdo_i   (TDO),
    .tdi_o   (TDI),
    .cap_o   (cap),
    .busy_o  (busy)
  );

`ifdef SCAN_MASTER_TDO_CHECK_EN
  logic [MAX_LEN-1:0] exp_q;
  logic [MAX_LEN-1:0] mask_q;
  logic               scan_q;
  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] len_mask;

  always_comb begin
    eff_len  = (cmd_type == CMD_IR) ? LEN_W'(IR_LEN) : cmd_len;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(eff_len));
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      exp_q  <= '0;
      mask_q <= '0;
      scan_q <= 1'b0;
    end else if (hs) begin
      exp_q  <= cmd_exp;
      mask_q <= cmd_mask & len_mask;
      scan_q <= (cmd_type == CMD_IR) || ((cmd_type == CMD_DR) && dr_legal);
    end
  end

  assign rsp_mismatch = rsp_valid_q & scan_q & (|((cap ^ exp_q) & mask_q));
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = cap;
  assign TMS       = tms_q;

endmodule

// File: tb/tb_scan_master.sv
// Randomized self-checking bench for scan_master against a sequence-level reference model.
module tb_scan_master;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam int IR_LEN  = 2;
  localparam int TDO_LAT = 1;

  logic               TCK = 1'b0;
  logic               TRST = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_type = 2'b00;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               TMS;
  logic               TDI;
  logic               TDO = 1'b0;
`ifdef SCAN_MASTER_TDO_CHECK_EN
  logic [MAX_LEN-1:0] cmd_exp = '0;
  logic [MAX_LEN-1:0] cmd_mask = '0;
  logic               rsp_mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [MAX_LEN-1:0] last_rsp;

  always #5 TCK = ~TCK;

  scan_master #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .IR_LEN  (IR_LEN),
    .TDO_LAT (TDO_LAT)
  ) dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
`ifdef SCAN_MASTER_TDO_CHECK_EN
    ,
    .cmd_exp      (cmd_exp),
    .cmd_mask     (cmd_mask),
    .rsp_mismatch (rsp_mismatch)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  // Called in the first cycle after TRST release: 5 x TMS=1, 1 x TMS=0, then ready.
  task automatic check_reset_seq(input string tag);
    logic [63:0] tms_obs;
    logic        busy_out;
    tms_obs  = '0;
    busy_out = 1'b0;
    for (int e = 0; e < 6; e++) begin
      tms_obs[e] = TMS;
      busy_out   = busy_out | cmd_ready | rsp_valid | TDI | rsp_err | (|rsp_data);
      TDO        = 1'($urandom);
      tick();
    end
    chk({tag, "_tms_seq"}, tms_obs, 64'h1F);
    chk({tag, "_quiet"}, 64'(busy_out), 64'h0);
    chk({tag, "_ready"}, 64'(cmd_ready), 64'h1);
  endtask

  task automatic do_cmd(input logic [1:0] typ, input int len, input logic [MAX_LEN-1:0] data,
                        input bit loop, input int hold);
    logic [63:0]        tms_exp, tms_obs, tdi_exp, tdi_obs;
    logic [MAX_LEN-1:0] rsp_exp;
    logic               tdo_h [64];
    logic               prev_tdi, seen, stable;
    int                 w, n, start, total, p;
    bit                 is_ir, is_dr, is_rst;

    w = 0;
    while (!cmd_ready && w < 100) begin
      tick();
      w++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", 64'(cmd_ready), 64'h1);
      return;
    end

    is_ir  = (typ == 2'b00);
    is_dr  = (typ == 2'b01) && (len >= 1) && (len <= MAX_LEN);
    is_rst = (typ == 2'b10);

    cmd_valid = 1'b1;
    cmd_type  = typ;
    cmd_len   = len[LEN_W-1:0];
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cmd_len   = LEN_W'($urandom);
    cmd_data  = $urandom;

    tms_exp = '0;
    tdi_exp = '0;
    rsp_exp = '0;
    n = 0;
    start = 0;
    total = 0;

    if (!(is_ir || is_dr || is_rst)) begin
      chk("illegal_valid", 64'(rsp_valid), 64'h1);
      chk("illegal_err", 64'(rsp_err), 64'h1);
      chk("illegal_data", 64'(rsp_data), 64'h0);
      chk("illegal_tms", 64'(TMS), 64'h0);
    end else begin
      if (is_rst) begin
        tms_exp = 64'h1F;
        total   = 6;
      end else begin
        n = is_ir ? IR_LEN : len;
        tms_exp[0] = 1'b1;
        if (is_ir) begin
          tms_exp[1] = 1'b1;
          p = 4;
        end else begin
          p = 3;
        end
        start = p;
        p = p + n;
        tms_exp[p-1] = 1'b1;
        tms_exp[p]   = 1'b1;
        total = p + 2;
        for (int k = 0; k < n; k++) tdi_exp[start+k] = data[k];
      end

      tms_obs  = '0;
      tdi_obs  = '0;
      prev_tdi = 1'b0;
      seen     = 1'b0;
      for (int e = 0; e < total; e++) begin
        tms_obs[e] = TMS;
        tdi_obs[e] = TDI;
        seen       = seen | cmd_ready | rsp_valid;
        TDO        = loop ? prev_tdi : 1'($urandom);
        tdo_h[e]   = TDO;
        prev_tdi   = TDI;
        tick();
      end
      for (int k = 0; k < n; k++) rsp_exp[k] = tdo_h[start+k+TDO_LAT];

      chk("tms_seq", tms_obs, tms_exp);
      chk("tdi_seq", tdi_obs, tdi_exp);
      chk("busy_quiet", 64'(seen), 64'h0);
      chk("rsp_valid", 64'(rsp_valid), 64'h1);
      chk("rsp_err", 64'(rsp_err), 64'h0);
      chk("rsp_data", 64'(rsp_data), 64'(rsp_exp));
      last_rsp = rsp_data;
    end

    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      stable = stable & rsp_valid & ~cmd_ready & (rsp_data === rsp_exp);
    end
    if (hold > 0) chk("hold_stable", 64'(stable), 64'h1);

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("accept_valid_low", 64'(rsp_valid), 64'h0);
    chk("accept_ready", 64'(cmd_ready), 64'h1);
  endtask

  task automatic mid_scan_reset();
    int w;
    w = 0;
    while (!cmd_ready && w < 100) begin
      tick();
      w++;
    end
    chk("mr_start_ready", 64'(cmd_ready), 64'h1);
    cmd_valid = 1'b1;
    cmd_type  = 2'b01;
    cmd_len   = LEN_W'(16);
    cmd_data  = $urandom;
    tick();
    cmd_valid = 1'b0;
    // edges 0..2 lead into Shift-DR; edge 7 is the fifth shift edge
    for (int e = 0; e < 7; e++) begin
      TDO = 1'($urandom);
      tick();
    end
    TRST = 1'b1;
    #1;
    chk("mr_tms", 64'(TMS), 64'h1);
    chk("mr_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("mr_tdi", 64'(TDI), 64'h0);
    chk("mr_ready", 64'(cmd_ready), 64'h0);
    tick();
    tick();
    TRST = 1'b0;
    check_reset_seq("mr");
    chk("mr_no_rsp", 64'(rsp_valid), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    TRST = 1'b1;
    tick();
    tick();
    chk("rst_tms", 64'(TMS), 64'h1);
    chk("rst_tdi", 64'(TDI), 64'h0);
    chk("rst_ready", 64'(cmd_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data", 64'(rsp_data), 64'h0);
    chk("rst_rsp_err", 64'(rsp_err), 64'h0);
    TRST = 1'b0;
    check_reset_seq("por");

    do_cmd(2'b00, 0, 32'h2, 1'b0, 0);
    do_cmd(2'b01, 8, 32'hA5, 1'b1, 0);
    chk("loop_a5", 64'(last_rsp), 64'hA5);
    do_cmd(2'b01, 0, 32'h1234, 1'b0, 0);
    do_cmd(2'b01, 33, 32'h5678, 1'b0, 0);
    do_cmd(2'b11, 8, 32'h9, 1'b0, 0);
    do_cmd(2'b01, 12, $urandom, 1'b0, 10);
    do_cmd(2'b10, 0, 32'h0, 1'b0, 2);
    do_cmd(2'b01, 1, 32'h1, 1'b0, 0);
    do_cmd(2'b01, MAX_LEN, $urandom, 1'b1, 1);
    mid_scan_reset();

    for (int i = 0; i < 40; i++) begin
      int          sel;
      int          len;
      logic [1:0]  typ;
      sel = $urandom_range(0, 9);
      len = 0;
      if (sel < 2) begin
        typ = 2'b00;
      end else if (sel < 7) begin
        typ = 2'b01;
        len = $urandom_range(1, MAX_LEN);
      end else if (sel == 7) begin
        typ = 2'b01;
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 63);
      end else if (sel == 8) begin
        typ = 2'b11;
        len = $urandom_range(0, 63);
      end else begin
        typ = 2'b10;
      end
      do_cmd(typ, len, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
